// File: rtl/time_preset_bcd.sv
// time_preset_bcd
//   Holds the starting clock of both chess players as BCD MM:SS and lets the
//   operator adjust it with up/down buttons before play starts. A press steps
//   once. Holding the button steps again after REPEAT_DELAY cycles, and then
//   every REPEAT_RATE cycles. The countdown block loads the outputs when the
//   game begins.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   enable              1 = setting allowed (game not running)
//   btn_up, btn_down    debounced button levels
//   field_sel           0 = minutes, 1 = seconds
//   player_sel          0 = player 1, 1 = player 2 (ignored when link = 1)
//   link                1 = every step goes to both players
//   load_default        restore DEF_MIN:DEF_SEC on both players
//   min_p1/sec_p1       player 1 BCD {tens,units}
//   min_p2/sec_p2       player 2 BCD {tens,units}
//   step_pulse          one-cycle pulse on every applied step or load
module time_preset_bcd #(
  parameter int MAX_MIN      = 59,
  parameter int DEF_MIN      = 5,
  parameter int DEF_SEC      = 0,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       field_sel,
  input  logic       player_sel,
  input  logic       link,
  input  logic       load_default,
  output logic [7:0] min_p1,
  output logic [7:0] sec_p1,
  output logic [7:0] min_p2,
  output logic [7:0] sec_p2,
  output logic       step_pulse
);

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  localparam logic [7:0] MAX_MIN_BCD = to_bcd(MAX_MIN);
  localparam logic [7:0] MAX_SEC_BCD = 8'h59;
  localparam logic [7:0] DEF_MIN_BCD = to_bcd(DEF_MIN);
  localparam logic [7:0] DEF_SEC_BCD = to_bcd(DEF_SEC);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  // Wrapping BCD increment: the units digit rolls over into the tens digit.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v == lim)              return 8'h00;
    else if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
    else                       return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Wrapping BCD decrement: the units digit borrows from the tens digit.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lim);
    if (v == 8'h00)            return lim;
    else if (v[3:0] == 4'd0)   return {v[7:4] - 4'd1, 4'd9};
    else                       return {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] lim,
                                          input logic up);
    return up ? bcd_inc(v, lim) : bcd_dec(v, lim);
  endfunction

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;      // 1 = the held button is btn_up
  logic             btn_up_q, btn_down_q;
  logic [7:0]       min_p1_q, min_p1_d, sec_p1_q, sec_p1_d;
  logic [7:0]       min_p2_q, min_p2_d, sec_p2_q, sec_p2_d;
  logic             step_pulse_q, step_pulse_d;

  logic do_step, step_up, press_up, press_dn, held_ok;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    min_p1_d     = min_p1_q;
    sec_p1_d     = sec_p1_q;
    min_p2_d     = min_p2_q;
    sec_p2_d     = sec_p2_q;
    step_pulse_d = 1'b0;
    do_step      = 1'b0;
    step_up      = 1'b0;

    press_up = btn_up   & ~btn_up_q   & ~btn_down;
    press_dn = btn_down & ~btn_down_q & ~btn_up;
    // The held button must stay high and the other one must stay low.
    held_ok  = dir_q ? (btn_up & ~btn_down) : (btn_down & ~btn_up);

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (load_default) begin
      min_p1_d     = DEF_MIN_BCD;
      sec_p1_d     = DEF_SEC_BCD;
      min_p2_d     = DEF_MIN_BCD;
      sec_p2_d     = DEF_SEC_BCD;
      step_pulse_d = 1'b1;
      state_d      = IDLE;
      cnt_d        = '0;
    end else if (btn_up && btn_down) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (press_up || press_dn) begin
            do_step = 1'b1;
            step_up = press_up;
            dir_d   = press_up;
            cnt_d   = '0;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (!held_ok) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DELAY_LAST) begin
            do_step = 1'b1;
            step_up = dir_q;
            cnt_d   = '0;
            state_d = REPEAT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (!held_ok) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == RATE_LAST) begin
            do_step = 1'b1;
            step_up = dir_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Each targeted channel steps from its own current value.
    if (do_step) begin
      step_pulse_d = 1'b1;
      if (link || !player_sel) begin
        if (field_sel) sec_p1_d = bcd_step(sec_p1_q, MAX_SEC_BCD, step_up);
        else           min_p1_d = bcd_step(min_p1_q, MAX_MIN_BCD, step_up);
      end
      if (link || player_sel) begin
        if (field_sel) sec_p2_d = bcd_step(sec_p2_q, MAX_SEC_BCD, step_up);
        else           min_p2_d = bcd_step(min_p2_q, MAX_MIN_BCD, step_up);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      min_p1_q     <= DEF_MIN_BCD;
      sec_p1_q     <= DEF_SEC_BCD;
      min_p2_q     <= DEF_MIN_BCD;
      sec_p2_q     <= DEF_SEC_BCD;
      step_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      min_p1_q     <= min_p1_d;
      sec_p1_q     <= sec_p1_d;
      min_p2_q     <= min_p2_d;
      sec_p2_q     <= sec_p2_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  // Button history keeps sampling through reset and while disabled. A button
  // that is still held afterwards then does not count as a fresh press.
  always_ff @(posedge clk) begin
    btn_up_q   <= btn_up;
    btn_down_q <= btn_down;
  end

  assign min_p1     = min_p1_q;
  assign sec_p1     = sec_p1_q;
  assign min_p2     = min_p2_q;
  assign sec_p2     = sec_p2_q;
  assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_time_preset_bcd.sv
module tb_time_preset_bcd;
  localparam int MAXM = 59, DM = 5, DS = 0, RD = 8, RR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, enable = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic field_sel = 1'b0, player_sel = 1'b0, link = 1'b0, load_default = 1'b0;
  logic [7:0] min_p1, sec_p1, min_p2, sec_p2;
  logic step_pulse;

  time_preset_bcd #(.MAX_MIN(MAXM), .DEF_MIN(DM), .DEF_SEC(DS),
                    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .rst(rst), .enable(enable), .btn_up(btn_up), .btn_down(btn_down),
    .field_sel(field_sel), .player_sel(player_sel), .link(link),
    .load_default(load_default), .min_p1(min_p1), .sec_p1(sec_p1),
    .min_p2(min_p2), .sec_p2(sec_p2), .step_pulse(step_pulse));

  int n_tests = 0, n_fail = 0;

  // Reference model: plain integer values, and button hold age counted in cycles.
  int mm[2], ss[2];
  bit act, adir, mpulse, pu, pd;
  int age;

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction

  function automatic void apply(input bit up);
    mpulse = 1'b1;
    for (int ch = 0; ch < 2; ch++) begin
      if (link || (int'(player_sel) == ch)) begin
        if (field_sel) ss[ch] = up ? (ss[ch] + 1) % 60 : (ss[ch] + 59) % 60;
        else           mm[ch] = up ? (mm[ch] + 1) % (MAXM + 1) : (mm[ch] + MAXM) % (MAXM + 1);
      end
    end
  endfunction

  function automatic void model_step();
    mpulse = 1'b0;
    if (rst) begin
      mm = '{DM, DM}; ss = '{DS, DS}; act = 1'b0;
    end else if (!enable) begin
      act = 1'b0;
    end else if (load_default) begin
      mm = '{DM, DM}; ss = '{DS, DS}; act = 1'b0; mpulse = 1'b1;
    end else if (btn_up && btn_down) begin
      act = 1'b0;
    end else if (act) begin
      if (adir ? btn_up : btn_down) begin
        age++;
        if (age == RD || (age > RD && (age - RD) % RR == 0)) apply(adir);
      end else begin
        act = 1'b0;
      end
    end else if (btn_up && !pu) begin
      apply(1'b1); act = 1'b1; adir = 1'b1; age = 0;
    end else if (btn_down && !pd) begin
      apply(1'b0); act = 1'b1; adir = 1'b0; age = 0;
    end
    pu = btn_up;
    pd = btn_down;
  endfunction

  function automatic logic [32:0] dut_vec();
    return {min_p1, sec_p1, min_p2, sec_p2, step_pulse};
  endfunction

  function automatic logic [32:0] mdl_vec();
    return {bcd(mm[0]), bcd(ss[0]), bcd(mm[1]), bcd(ss[1]), mpulse};
  endfunction

  task automatic chk(input string nm, input logic [32:0] got, input logic [32:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic tick(input bit r, e, u, d, f, p, l, ld);
    rst = r; enable = e; btn_up = u; btn_down = d;
    field_sel = f; player_sel = p; link = l; load_default = ld;
    @(posedge clk);
    model_step();
    #1;
    chk("model", dut_vec(), mdl_vec());
  endtask

  typedef struct {
    bit r, e, u, d, f, p, l, ld;
    logic [7:0] m1, s1, m2, s2;
    bit pl;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit r, e, u, d, f, p, l, ld,
                              input logic [7:0] m1, s1, m2, s2, input bit pl);
    vec_t v;
    v.r = r; v.e = e; v.u = u; v.d = d; v.f = f; v.p = p; v.l = l; v.ld = ld;
    v.m1 = m1; v.s1 = s1; v.m2 = m2; v.s2 = s2; v.pl = pl;
    tbl.push_back(v);
  endfunction

  initial begin
    int steps;
    bit ru, rdn;

    // Reset, single step, seconds wrap on player 2, linked minutes wrap.
    add(1,0,0,0,0,0,0,0, 8'h05,8'h00,8'h05,8'h00, 0);
    add(0,1,0,0,0,0,0,0, 8'h05,8'h00,8'h05,8'h00, 0);
    add(0,1,1,0,0,0,0,0, 8'h06,8'h00,8'h05,8'h00, 1);
    add(0,1,0,0,0,0,0,0, 8'h06,8'h00,8'h05,8'h00, 0);
    add(0,1,0,1,1,1,0,0, 8'h06,8'h00,8'h05,8'h59, 1);
    add(0,1,0,0,1,1,0,0, 8'h06,8'h00,8'h05,8'h59, 0);
    add(0,1,1,0,1,1,0,0, 8'h06,8'h00,8'h05,8'h00, 1);
    add(0,1,0,0,1,1,0,0, 8'h06,8'h00,8'h05,8'h00, 0);
    add(0,1,0,1,1,1,0,0, 8'h06,8'h00,8'h05,8'h59, 1);
    add(0,1,0,0,1,1,0,0, 8'h06,8'h00,8'h05,8'h59, 0);
    for (int k = 1; k <= 7; k++) begin
      add(0,1,0,1,0,0,1,0, bcd((66 - k) % 60), 8'h00, bcd((65 - k) % 60), 8'h59, 1);
      add(0,1,0,0,0,0,1,0, bcd((66 - k) % 60), 8'h00, bcd((65 - k) % 60), 8'h59, 0);
    end
    add(0,0,1,0,0,0,0,0, 8'h59,8'h00,8'h58,8'h59, 0);
    add(0,1,0,0,0,0,0,0, 8'h59,8'h00,8'h58,8'h59, 0);

    foreach (tbl[i]) begin
      tick(tbl[i].r, tbl[i].e, tbl[i].u, tbl[i].d, tbl[i].f, tbl[i].p, tbl[i].l, tbl[i].ld);
      chk($sformatf("vec%0d", i), dut_vec(),
          {tbl[i].m1, tbl[i].s1, tbl[i].m2, tbl[i].s2, tbl[i].pl});
    end

    // Auto-repeat from 09: steps at hold cycles 0, 8, 11, 14, 17.
    tick(0,1,0,0,0,0,0,1);
    chk("load_default", dut_vec(), {8'h05, 8'h00, 8'h05, 8'h00, 1'b1});
    for (int k = 0; k < 4; k++) begin
      tick(0,1,1,0,0,0,0,0);
      tick(0,1,0,0,0,0,0,0);
    end
    chk("pre_hold", {25'b0, min_p1}, {25'b0, 8'h09});
    for (int i = 0; i < 20; i++) begin
      tick(0,1,1,0,0,0,0,0);
      chk($sformatf("hold_pulse%0d", i), {32'b0, step_pulse},
          {32'b0, (i == 0 || i == 8 || i == 11 || i == 14 || i == 17)});
      if (i == 0) chk("tens_carry", {25'b0, min_p1}, {25'b0, 8'h10});
    end
    chk("hold_end", dut_vec(), {8'h14, 8'h00, 8'h05, 8'h00, 1'b0});
    tick(0,1,0,0,0,0,0,0);

    // Both buttons, then presses while disabled.
    tick(0,1,1,1,0,0,0,0);
    chk("both_high", dut_vec(), {8'h14, 8'h00, 8'h05, 8'h00, 1'b0});
    tick(0,1,0,0,0,0,0,0);
    tick(0,0,1,0,0,0,0,0);
    chk("disabled_press", dut_vec(), {8'h14, 8'h00, 8'h05, 8'h00, 1'b0});
    tick(0,0,1,0,0,0,0,1);
    chk("disabled_load", dut_vec(), {8'h14, 8'h00, 8'h05, 8'h00, 1'b0});
    steps = 0;
    for (int i = 0; i < 12; i++) begin
      tick(0,1,1,0,0,0,0,0);
      steps += int'(step_pulse);
    end
    chk("held_after_enable", 33'(steps), 33'd0);
    tick(0,1,0,0,0,0,0,0);

    // load_default beats a button in REPEAT, then reset mid-hold.
    for (int i = 0; i < 12; i++) tick(0,1,1,0,1,0,1,0);
    tick(0,1,1,0,1,0,1,1);
    chk("load_in_repeat", dut_vec(), {8'h05, 8'h00, 8'h05, 8'h00, 1'b1});
    steps = 0;
    for (int i = 0; i < 12; i++) begin
      tick(0,1,1,0,1,0,1,0);
      steps += int'(step_pulse);
    end
    chk("held_after_load", 33'(steps), 33'd0);
    tick(0,1,0,0,0,1,0,0);
    tick(0,1,1,0,0,1,0,0);
    chk("repress", dut_vec(), {8'h05, 8'h00, 8'h06, 8'h00, 1'b1});
    for (int i = 0; i < 3; i++) tick(0,1,1,0,0,1,0,0);
    tick(1,1,1,0,0,1,0,0);
    chk("rst_mid_hold", dut_vec(), {8'h05, 8'h00, 8'h05, 8'h00, 1'b0});
    steps = 0;
    for (int i = 0; i < 12; i++) begin
      tick(0,1,1,0,0,1,0,0);
      steps += int'(step_pulse);
    end
    chk("held_after_rst", 33'(steps), 33'd0);
    tick(0,1,0,0,0,1,0,0);
    tick(0,1,1,0,0,1,0,0);
    chk("repress_after_rst", dut_vec(), {8'h05, 8'h00, 8'h06, 8'h00, 1'b1});

    // Random stimulus against the model.
    ru = 1'b0; rdn = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(9) == 0) ru = ~ru;
      if ($urandom_range(11) == 0) rdn = ~rdn;
      tick($urandom_range(249) == 0, $urandom_range(24) != 0, ru, rdn,
           1'($urandom), 1'($urandom), $urandom_range(3) == 0, $urandom_range(119) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
